// File: rtl/diagv2_test_sequencer.sv
// Hardware regression sequencer: load each test image, reset and run the diagv2 core,
// wait for ecall or a cycle-budget timeout, and stream one result record per test.
module diagv2_test_sequencer #(
    parameter int NUM_TESTS    = 39,
    parameter int DATA_W       = 64,
    parameter int CYC_W        = 24,
    parameter int RESET_CYCLES = 2,
    localparam int IDX_W       = $clog2(NUM_TESTS + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic              stop_on_fail,
    input  logic [CYC_W-1:0]  timeout_limit,
    output logic              load_req,
    input  logic              load_ack,
    output logic [IDX_W-1:0]  test_idx,
    output logic              core_reset,
    output logic              core_halt,
    input  logic              ecall,
    input  logic [DATA_W-1:0] status_code,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [IDX_W-1:0]  result_idx,
    output logic [DATA_W-1:0] result_status,
    output logic              result_pass,
    output logic              result_timeout,
    output logic [CYC_W-1:0]  result_cycles,
    output logic [IDX_W-1:0]  pass_count,
    output logic [IDX_W-1:0]  fail_count,
    output logic [IDX_W-1:0]  timeout_count,
    output logic              busy,
    output logic              done,
    output logic [2:0]        fsm_state
);

    localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RST    = 3'd2,
        S_RUN    = 3'd3,
        S_RECORD = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CYC_W-1:0]  cyc_cnt;
    logic [CYC_W-1:0]  cyc_inc;
    logic [CYC_W-1:0]  limit;
    logic              stop_mode;
    logic [RC_W-1:0]   rst_cnt;
    logic              accept;
    logic              last_test;
    logic              hit_limit;
    logic              end_run;

    assign fsm_state = state;
    assign cyc_inc   = (&cyc_cnt) ? cyc_cnt : cyc_cnt + 1'b1;
    assign hit_limit = (limit != '0) && (cyc_inc == limit);
    assign accept    = (state == S_RECORD) && result_ready;
    assign last_test = (test_idx == IDX_W'(NUM_TESTS - 1));
    assign end_run   = (!result_pass && stop_mode) || last_test;

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (start) state_next = S_LOAD;
                S_LOAD:         if (load_ack) state_next = S_RST;
                S_RST:          if (rst_cnt == RC_W'(RESET_CYCLES - 1)) state_next = S_RUN;
                S_RUN:          if (ecall || hit_limit) state_next = S_RECORD;
                S_RECORD:       if (accept) state_next = end_run ? S_DONE : S_LOAD;
                default:        state_next = S_IDLE;
            endcase
        end
    end

    // Control outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            load_req       <= 1'b0;
            core_reset     <= 1'b1;
            core_halt      <= 1'b1;
            result_valid   <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            test_idx       <= '0;
            result_idx     <= '0;
            result_status  <= '0;
            result_pass    <= 1'b0;
            result_timeout <= 1'b0;
            result_cycles  <= '0;
            pass_count     <= '0;
            fail_count     <= '0;
            timeout_count  <= '0;
            cyc_cnt        <= '0;
            limit          <= '0;
            stop_mode      <= 1'b0;
            rst_cnt        <= '0;
        end else begin
            state        <= state_next;
            load_req     <= (state_next == S_LOAD);
            core_reset   <= (state_next == S_IDLE) || (state_next == S_LOAD) ||
                            (state_next == S_RST)  || (state_next == S_DONE);
            core_halt    <= (state_next == S_IDLE) || (state_next == S_LOAD) ||
                            (state_next == S_RECORD) || (state_next == S_DONE);
            result_valid <= (state_next == S_RECORD);
            busy         <= (state_next != S_IDLE) && (state_next != S_DONE);
            done         <= (state_next == S_DONE);

            if (!abort) begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            test_idx      <= '0;
                            pass_count    <= '0;
                            fail_count    <= '0;
                            timeout_count <= '0;
                            stop_mode     <= stop_on_fail;
                            limit         <= timeout_limit;
                        end
                    end
                    S_LOAD: rst_cnt <= '0;
                    S_RST: begin
                        rst_cnt <= rst_cnt + 1'b1;
                        cyc_cnt <= '0;
                    end
                    S_RUN: begin
                        cyc_cnt <= cyc_inc;
                        // ecall beats a timeout landing on the same cycle
                        if (ecall) begin
                            result_idx     <= test_idx;
                            result_status  <= status_code;
                            result_pass    <= (status_code == '0);
                            result_timeout <= 1'b0;
                            result_cycles  <= cyc_inc;
                        end else if (hit_limit) begin
                            result_idx     <= test_idx;
                            result_status  <= '0;
                            result_pass    <= 1'b0;
                            result_timeout <= 1'b1;
                            result_cycles  <= cyc_inc;
                        end
                    end
                    S_RECORD: begin
                        if (accept) begin
                            if (result_pass) begin
                                pass_count <= pass_count + 1'b1;
                            end else begin
                                fail_count <= fail_count + 1'b1;
                                if (result_timeout) timeout_count <= timeout_count + 1'b1;
                            end
                            if (!end_run) test_idx <= test_idx + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_diagv2_test_sequencer.sv
// Self-checking bench for diagv2_test_sequencer: loader and core models respond to the
// sequencer while a scoreboard compares each result record against its expected value.
module tb_diagv2_test_sequencer;

    localparam int NT    = 3;
    localparam int DW    = 64;
    localparam int CW    = 24;
    localparam int RC    = 2;
    localparam int IW    = $clog2(NT + 1);

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [DW-1:0] status;
        logic          pass;
        logic          timeout;
        logic [CW-1:0] cycles;
    } rec_t;
    localparam int REC_W = $bits(rec_t);

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          abort;
    logic          stop_on_fail;
    logic [CW-1:0] timeout_limit;
    logic          load_req;
    logic          load_ack;
    logic [IW-1:0] test_idx;
    logic          core_reset;
    logic          core_halt;
    logic          ecall;
    logic [DW-1:0] status_code;
    logic          result_valid;
    logic          result_ready;
    logic [IW-1:0] result_idx;
    logic [DW-1:0] result_status;
    logic          result_pass;
    logic          result_timeout;
    logic [CW-1:0] result_cycles;
    logic [IW-1:0] pass_count;
    logic [IW-1:0] fail_count;
    logic [IW-1:0] timeout_count;
    logic          busy;
    logic          done;
    logic [2:0]    fsm_state;

    logic [REC_W-1:0] exp_q[$];
    int               n_vec = 0;
    int               n_err = 0;
    int               sc_ecall_at[NT];
    logic [DW-1:0]    sc_status[NT];
    int               ready_delay = 0;
    bit               loader_en = 1'b1;
    bit               saw_idx2 = 1'b0;
    int               acc_pass = 0;
    int               acc_fail = 0;
    int               acc_to = 0;
    int               exp_pass = 0;
    int               exp_fail = 0;
    int               exp_to = 0;

    diagv2_test_sequencer #(
        .NUM_TESTS(NT), .DATA_W(DW), .CYC_W(CW), .RESET_CYCLES(RC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .stop_on_fail(stop_on_fail), .timeout_limit(timeout_limit),
        .load_req(load_req), .load_ack(load_ack), .test_idx(test_idx),
        .core_reset(core_reset), .core_halt(core_halt), .ecall(ecall),
        .status_code(status_code), .result_valid(result_valid),
        .result_ready(result_ready), .result_idx(result_idx),
        .result_status(result_status), .result_pass(result_pass),
        .result_timeout(result_timeout), .result_cycles(result_cycles),
        .pass_count(pass_count), .fail_count(fail_count),
        .timeout_count(timeout_count), .busy(busy), .done(done),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Loader: acknowledges two cycles after each request.
    initial begin
        int lcnt;
        lcnt     = 0;
        load_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (load_req && test_idx == 2) saw_idx2 = 1'b1;
            if (load_req && loader_en && reset_n) begin
                lcnt++;
                load_ack = (lcnt == 2);
            end else begin
                lcnt     = 0;
                load_ack = 1'b0;
            end
        end
    end

    // Core: counts its running cycles and raises ecall on the scheduled one.
    initial begin
        int run_cnt;
        run_cnt     = 0;
        ecall       = 1'b0;
        status_code = '0;
        forever begin
            @(negedge clk);
            if (!core_reset && !core_halt) run_cnt++;
            else run_cnt = 0;
            if (run_cnt != 0 && run_cnt == sc_ecall_at[test_idx]) begin
                ecall       = 1'b1;
                status_code = sc_status[test_idx];
            end else begin
                ecall = 1'b0;
            end
        end
    end

    // Result consumer / scoreboard.
    initial begin
        int   held;
        rec_t e;
        held         = 0;
        result_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (result_valid && reset_n) begin
                if (exp_q.size() == 0) begin
                    check("rec_unexpected", 96'(exp_q.size()), 96'd1);
                    result_ready = 1'b1;
                end else if (held < ready_delay) begin
                    e = rec_t'(exp_q[0]);
                    result_ready = 1'b0;
                    held++;
                    check("stall_idx", 96'(result_idx), 96'(e.idx));
                    check("stall_cycles", 96'(result_cycles), 96'(e.cycles));
                    check("stall_halt", 96'(core_halt), 96'd1);
                    check("stall_pass_cnt", 96'(pass_count), 96'(acc_pass));
                    check("stall_fail_cnt", 96'(fail_count), 96'(acc_fail));
                end else begin
                    e = rec_t'(exp_q.pop_front());
                    result_ready = 1'b1;
                    held = 0;
                    check("rec_idx", 96'(result_idx), 96'(e.idx));
                    check("rec_status", 96'(result_status), 96'(e.status));
                    check("rec_pass", 96'(result_pass), 96'(e.pass));
                    check("rec_timeout", 96'(result_timeout), 96'(e.timeout));
                    check("rec_cycles", 96'(result_cycles), 96'(e.cycles));
                    if (e.pass) acc_pass++;
                    else acc_fail++;
                    if (e.timeout) acc_to++;
                end
            end else begin
                result_ready = 1'b0;
                held = 0;
            end
        end
    end

    // Sets up one run's core behaviour, pushes its expected records and pulses start.
    task automatic run_start(input int ea0, input int ea1, input int ea2,
                             input logic [DW-1:0] st1, input logic [CW-1:0] lim, input bit stop);
        rec_t r;
        sc_ecall_at[0] = ea0; sc_ecall_at[1] = ea1; sc_ecall_at[2] = ea2;
        sc_status[0] = '0; sc_status[1] = st1; sc_status[2] = '0;
        acc_pass = 0; acc_fail = 0; acc_to = 0;
        exp_pass = 0; exp_fail = 0; exp_to = 0;
        for (int i = 0; i < NT; i++) begin
            if (sc_ecall_at[i] == 0 && lim == 0) break;
            r.idx = IW'(i);
            if (sc_ecall_at[i] != 0 && (lim == 0 || sc_ecall_at[i] <= int'(lim))) begin
                r.status  = sc_status[i];
                r.pass    = (sc_status[i] == '0);
                r.timeout = 1'b0;
                r.cycles  = CW'(sc_ecall_at[i]);
            end else begin
                r.status  = '0;
                r.pass    = 1'b0;
                r.timeout = 1'b1;
                r.cycles  = lim;
            end
            exp_q.push_back(REC_W'(r));
            if (r.pass) exp_pass++;
            else exp_fail++;
            if (r.timeout) exp_to++;
            if (!r.pass && stop) break;
        end
        stop_on_fail  = stop;
        timeout_limit = lim;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("load_req_after_start", 96'(load_req), 96'd1);
    endtask

    task automatic finish_run(input string tag);
        for (int i = 0; i < 3000 && !done; i++) @(negedge clk);
        check({tag, "_done"}, 96'(done), 96'd1);
        check({tag, "_pass_cnt"}, 96'(pass_count), 96'(exp_pass));
        check({tag, "_fail_cnt"}, 96'(fail_count), 96'(exp_fail));
        check({tag, "_to_cnt"}, 96'(timeout_count), 96'(exp_to));
        check({tag, "_busy"}, 96'(busy), 96'd0);
        check({tag, "_core_reset"}, 96'(core_reset), 96'd1);
        check({tag, "_q_empty"}, 96'(exp_q.size()), 96'd0);
    endtask

    task automatic wait_pass_run(input string tag);
        for (int i = 0; i < 500 && !(pass_count == 1 && !core_reset && !core_halt); i++)
            @(negedge clk);
        check({tag, "_reached"}, 96'(pass_count == 1 && !core_reset && !core_halt), 96'd1);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        stop_on_fail = 1'b0; timeout_limit = '0;
        for (int i = 0; i < NT; i++) begin sc_ecall_at[i] = 0; sc_status[i] = '0; end
        repeat (3) @(negedge clk);
        check("rst_core_reset", 96'(core_reset), 96'd1);
        check("rst_core_halt", 96'(core_halt), 96'd1);
        check("rst_load_req", 96'(load_req), 96'd0);
        check("rst_result_valid", 96'(result_valid), 96'd0);
        check("rst_busy", 96'(busy), 96'd0);
        check("rst_done", 96'(done), 96'd0);
        check("rst_counts", 96'({pass_count, fail_count, timeout_count}), 96'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run_start(10, 10, 10, '0, '0, 1'b0);
        finish_run("all_pass");

        run_start(10, 10, 10, DW'(5), '0, 1'b0);
        finish_run("fail_cont");

        saw_idx2 = 1'b0;
        run_start(10, 10, 10, DW'(5), '0, 1'b1);
        finish_run("stop_fail");
        check("stop_no_load_idx2", 96'(saw_idx2), 96'd0);

        ready_delay = 5;
        run_start(0, 20, 5, '0, CW'(20), 1'b0);
        finish_run("timeout");
        ready_delay = 0;

        run_start(3, 0, 0, '0, '0, 1'b0);
        wait_pass_run("abort_run");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_run_busy", 96'(busy), 96'd0);
        check("abort_run_core_reset", 96'(core_reset), 96'd1);
        check("abort_run_pass_kept", 96'(pass_count), 96'd1);
        check("abort_run_q_empty", 96'(exp_q.size()), 96'd0);

        run_start(3, 0, 0, '0, '0, 1'b0);
        wait_pass_run("rst_run");
        reset_n = 1'b0;
        #1;
        check("rst_run_core_reset", 96'(core_reset), 96'd1);
        check("rst_run_core_halt", 96'(core_halt), 96'd1);
        check("rst_run_busy", 96'(busy), 96'd0);
        check("rst_run_counts", 96'({pass_count, fail_count, timeout_count}), 96'd0);
        check("rst_run_state", 96'(fsm_state), 96'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        loader_en = 1'b0;
        run_start(10, 10, 10, '0, '0, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_load_req", 96'(load_req), 96'd0);
        check("abort_load_busy", 96'(busy), 96'd0);
        check("abort_load_state", 96'(fsm_state), 96'd0);
        exp_q.delete();
        loader_en = 1'b1;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/diagv2_test_sequencer.md
# diagv2_test_sequencer

Synthesizable regression sequencer sitting between a test-image loader and the diagv2 core, replacing testbench-only sequencing with hardware. For each of `NUM_TESTS` images it requests a memory load, holds the core in reset, releases it, waits for `ecall` or a cycle-budget timeout, gates the core, and streams a per-test result record. It keeps pass/fail/timeout totals and optionally stops on the first failure.

## Interface
- `NUM_TESTS`, 39: number of test images; indices 0..NUM_TESTS-1.
- `DATA_W`, 64: width of the core status code (x10).
- `CYC_W`, 24: cycle-counter and timeout-limit width.
- `RESET_CYCLES`, 2: cycles `core_reset` is held per test (>=1).
- `IDX_W`, $clog2(NUM_TESTS+1): index/counter width (derived).

- `clk`  in  1  single clock, all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  pulse; begins a run from IDLE or DONE.
- `abort`  in  1  synchronous; any state -> IDLE next cycle.
- `stop_on_fail`  in  1  sampled at `start`; 1 = end run at first fail/timeout.
- `timeout_limit`  in  CYC_W  run-cycle budget per test; 0 = no timeout. Sampled at `start`.
- `load_req`  out  1  request loader to place image `test_idx`.
- `load_ack`  in  1  loader done; valid only while `load_req`=1.
- `test_idx`  out  IDX_W  current test index.
- `core_reset`  out  1  active-high reset to core.
- `core_halt`  out  1  clock-gate/halt to core (1 = frozen).
- `ecall`  in  1  core signals ecall.
- `status_code`  in  DATA_W  core x10.
- `result_valid`  out  1  result record valid.
- `result_ready`  in  1  consumer accepts record.
- `result_idx`  out  IDX_W; `result_status`  out  DATA_W; `result_pass`  out  1; `result_timeout`  out  1; `result_cycles`  out  CYC_W.
- `pass_count`, `fail_count`, `timeout_count`  out  IDX_W  totals (timeouts also counted in `fail_count`).
- `busy`  out  1  state not IDLE/DONE.
- `done`  out  1  run finished; held until `start`/`abort`.

## Operation
- States: IDLE, LOAD, RST, RUN, RECORD, DONE.
- IDLE: `core_reset`=1, `core_halt`=1. `start` -> clear counters, `test_idx`=0, latch `stop_on_fail`/`timeout_limit`, -> LOAD.
- LOAD: `load_req`=1, `core_reset`=1, `core_halt`=1. `load_ack`=1 -> RST (req drops same edge).
- RST: `core_reset`=1, `core_halt`=0 for exactly RESET_CYCLES cycles -> RUN; cycle counter cleared.
- RUN: `core_reset`=0, `core_halt`=0, counter += 1 per cycle (saturates at all-ones). `ecall`=1 -> capture status, pass = (status==0), timeout=0 -> RECORD. Else counter == limit (limit≠0) -> status=0, pass=0, timeout=1 -> RECORD. Ecall and timeout same cycle: ecall wins.
- RECORD: `core_halt`=1, `core_reset`=0, `result_valid`=1, record fields stable until accept. On `result_valid&&result_ready`: increment pass or fail (and timeout) counter; then fail && stop_on_fail -> DONE; `test_idx`==NUM_TESTS-1 -> DONE; else `test_idx`+1 -> LOAD.
- DONE: `done`=1, `core_reset`=1, `core_halt`=1; `start` restarts (counters cleared).
- `abort` has priority over all transitions; drops `load_req`/`result_valid` next cycle, counters retained.
- `start` ignored while `busy`.

## Timing
- Reset (async assert): state IDLE; `core_reset`=1, `core_halt`=1; all other outputs 0.
- `start` at edge N -> `load_req`=1 from N+1.
- `load_ack` at edge M -> `core_reset`=1/`core_halt`=0 for cycles M+1..M+RESET_CYCLES; RUN from M+RESET_CYCLES+1.
- `ecall` sampled at edge E -> `core_halt`=1 and `result_valid`=1 from E+1; `result_cycles` = RUN cycles including E's cycle.
- Accept at edge A -> counters updated and `load_req` (next test) or `done` from A+1.
- Totals never wrap (max NUM_TESTS fits IDX_W).

## Test plan
- NUM_TESTS=3, loader acks after 2 cycles, ecall with status 0 after 10 RUN cycles each -> 3 records, idx 0,1,2, pass_count=3, fail_count=0, `done`=1, `result_cycles`=10.
- Test 1 returns status 5, stop_on_fail=0 -> record pass=0 status=5; run continues; pass=2, fail=1.
- Same with stop_on_fail=1 -> `done` after record idx 1; no `load_req` for idx 2; fail_count=1.
- timeout_limit=20, no ecall -> record at RUN cycle 20, timeout=1, timeout_count=1; ecall and limit in same cycle -> timeout=0.
- `result_ready` held low 5 cycles -> record fields stable, `core_halt`=1, counters unchanged until accept.
- `reset_n` low mid-RUN -> immediate IDLE, `core_reset`=1, counters 0; `abort` in LOAD -> `load_req` low next cycle, IDLE.
